// File: rtl/ofdm_rx_sequencer.sv
// rtl/ofdm_rx_sequencer.sv - OFDM receive sequencer: search, guard removal and FFT sample framing
module ofdm_rx_sequencer #(
  parameter int symbol_length_g     = 64,
  parameter int guard_length_g      = 16,
  parameter int symbols_per_frame_g = 12,
  parameter int timeout_g           = 4096
) (
  input  logic                  sys_clk,
  input  logic                  sys_rstn,
  input  logic                  sys_init,
  input  logic                  rx_data_valid,
  input  logic                  frame_start,
  output logic                  align_enable,
  output logic                  fft_valid,
  output logic                  fft_start,
  output logic                  symbol_done,
  output logic                  frame_done,
  output logic [((symbols_per_frame_g > 1) ? $clog2(symbols_per_frame_g) : 1)-1:0] symbol_idx,
  output logic                  search_timeout,
  output logic                  busy
);

  localparam int MAX_A = (timeout_g > symbol_length_g) ? timeout_g : symbol_length_g;
  localparam int MAX_C = (MAX_A > guard_length_g) ? MAX_A : guard_length_g;
  localparam int CW    = $clog2(MAX_C + 1);
  localparam int IW    = (symbols_per_frame_g > 1) ? $clog2(symbols_per_frame_g) : 1;

  localparam logic [CW-1:0] TO_LAST  = CW'(timeout_g - 1);
  localparam logic [CW-1:0] GD_LAST  = CW'(guard_length_g - 1);
  localparam logic [CW-1:0] SY_LAST  = CW'(symbol_length_g - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(symbols_per_frame_g - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, GUARD, DATA} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            align_enable_q, align_enable_d;
  logic            fft_valid_q, fft_valid_d;
  logic            fft_start_q, fft_start_d;
  logic            symbol_done_q, symbol_done_d;
  logic            frame_done_q, frame_done_d;
  logic            search_timeout_q, search_timeout_d;
  logic            busy_q, busy_d;

  // One shared counter: search samples, guard samples or data samples, depending on state.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    idx_d            = idx_q;
    fft_valid_d      = 1'b0;
    fft_start_d      = 1'b0;
    symbol_done_d    = 1'b0;
    frame_done_d     = 1'b0;
    search_timeout_d = 1'b0;

    if (sys_init) begin
      state_d = SEARCH;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (rx_data_valid) begin
      case (state_q)
        SEARCH: begin
          if (frame_start) begin
            // The alignment sample itself is the first guard sample.
            if (guard_length_g <= 1) begin
              state_d = DATA;
              cnt_d   = '0;
            end else begin
              state_d = GUARD;
              cnt_d   = CW'(1);
            end
          end else if (cnt_q == TO_LAST) begin
            state_d          = IDLE;
            cnt_d            = '0;
            search_timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        GUARD: begin
          if (cnt_q == GD_LAST) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DATA: begin
          fft_valid_d = 1'b1;
          fft_start_d = (cnt_q == '0);
          if (cnt_q == SY_LAST) begin
            symbol_done_d = 1'b1;
            cnt_d         = '0;
            if (idx_q < IDX_LAST) begin
              idx_d   = idx_q + IW'(1);
              state_d = GUARD;
            end else begin
              frame_done_d = 1'b1;
              idx_d        = '0;
              state_d      = SEARCH;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end

    align_enable_d = (state_d == SEARCH);
    busy_d         = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      idx_q            <= '0;
      align_enable_q   <= 1'b0;
      fft_valid_q      <= 1'b0;
      fft_start_q      <= 1'b0;
      symbol_done_q    <= 1'b0;
      frame_done_q     <= 1'b0;
      search_timeout_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      idx_q            <= idx_d;
      align_enable_q   <= align_enable_d;
      fft_valid_q      <= fft_valid_d;
      fft_start_q      <= fft_start_d;
      symbol_done_q    <= symbol_done_d;
      frame_done_q     <= frame_done_d;
      search_timeout_q <= search_timeout_d;
      busy_q           <= busy_d;
    end
  end

  assign align_enable   = align_enable_q;
  assign fft_valid      = fft_valid_q;
  assign fft_start      = fft_start_q;
  assign symbol_done    = symbol_done_q;
  assign frame_done     = frame_done_q;
  assign symbol_idx     = idx_q;
  assign search_timeout = search_timeout_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_ofdm_rx_sequencer.sv
// tb/tb_ofdm_rx_sequencer.sv - directed self-checking bench for ofdm_rx_sequencer
module tb_ofdm_rx_sequencer;

  logic       clk;
  logic       sys_rstn;
  logic       sys_init;
  logic       rx_data_valid;
  logic       frame_start;
  logic       align_enable;
  logic       fft_valid;
  logic       fft_start;
  logic       symbol_done;
  logic       frame_done;
  logic [3:0] symbol_idx;
  logic       search_timeout;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int n_fv, n_fs, n_sd, n_fd;

  ofdm_rx_sequencer dut (
    .sys_clk        (clk),
    .sys_rstn       (sys_rstn),
    .sys_init       (sys_init),
    .rx_data_valid  (rx_data_valid),
    .frame_start    (frame_start),
    .align_enable   (align_enable),
    .fft_valid      (fft_valid),
    .fft_start      (fft_start),
    .symbol_done    (symbol_done),
    .frame_done     (frame_done),
    .symbol_idx     (symbol_idx),
    .search_timeout (search_timeout),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left on a falling edge; on return the outputs show the effect of this sample.
  task automatic send(input logic fs, input int gap);
    repeat (gap) @(negedge clk);
    rx_data_valid = 1'b1;
    frame_start   = fs;
    @(negedge clk);
    rx_data_valid = 1'b0;
    frame_start   = 1'b0;
  endtask

  task automatic do_init();
    sys_init = 1'b1;
    @(negedge clk);
    sys_init = 1'b0;
  endtask

  initial begin
    sys_rstn      = 1'b1;
    sys_init      = 1'b0;
    rx_data_valid = 1'b0;
    frame_start   = 1'b0;
    repeat (2) @(negedge clk);
    sys_rstn = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_align", 32'(align_enable), 0);
    chk("rst_fft_valid", 32'(fft_valid), 0);
    chk("rst_idx", 32'(symbol_idx), 0);
    chk("rst_timeout", 32'(search_timeout), 0);
    @(negedge clk);
    sys_rstn = 1'b1;
    repeat (3) send(1'b1, 1);
    chk("idle_hold_busy", 32'(busy), 0);
    chk("idle_hold_align", 32'(align_enable), 0);

    // Search with a sparse strobe, then a full default frame.
    do_init();
    chk("init_align", 32'(align_enable), 1);
    chk("init_busy", 32'(busy), 1);
    for (int i = 0; i < 10; i++) send(1'b0, 24);
    chk("search_align", 32'(align_enable), 1);
    send(1'b1, 24);
    chk("fs_align", 32'(align_enable), 0);
    chk("fs_busy", 32'(busy), 1);
    chk("fs_fft_valid", 32'(fft_valid), 0);
    n_fv = 0; n_fs = 0; n_sd = 0; n_fd = 0;
    for (int k = 2; k <= 960; k++) begin
      int p;
      p = (k - 1) % 80;
      if (k % 7 == 0) begin
        @(negedge clk);
        chk("gap_fft_valid", 32'(fft_valid), 0);
      end
      send(1'b0, 0);
      n_fv += int'(fft_valid);
      n_fs += int'(fft_start);
      n_sd += int'(symbol_done);
      n_fd += int'(frame_done);
      if (k == 16) chk("k16_fft_valid", 32'(fft_valid), 0);
      if (p == 16) chk("sym_idx", 32'(symbol_idx), 32'((k - 1) / 80));
      chk("frame_fft_start", 32'(fft_start), 32'(p == 16));
      chk("frame_symbol_done", 32'(symbol_done), 32'(p == 79));
      chk("frame_done_pos", 32'(frame_done), 32'(k == 960));
      chk("frame_align", 32'(align_enable), 32'(k == 960));
    end
    chk("cnt_fft_valid", 32'(n_fv), 768);
    chk("cnt_fft_start", 32'(n_fs), 12);
    chk("cnt_symbol_done", 32'(n_sd), 12);
    chk("cnt_frame_done", 32'(n_fd), 1);
    chk("post_frame_idx", 32'(symbol_idx), 0);
    chk("post_frame_busy", 32'(busy), 1);

    // Restart while inside the data part of symbol 5.
    do_init();
    send(1'b1, 0);
    for (int k = 2; k <= 430; k++) send(1'b0, 0);
    chk("sym5_idx", 32'(symbol_idx), 5);
    chk("sym5_fft_valid", 32'(fft_valid), 1);
    sys_init      = 1'b1;
    rx_data_valid = 1'b1;
    @(negedge clk);
    sys_init      = 1'b0;
    rx_data_valid = 1'b0;
    chk("reinit_align", 32'(align_enable), 1);
    chk("reinit_idx", 32'(symbol_idx), 0);
    chk("reinit_fft_valid", 32'(fft_valid), 0);
    chk("reinit_symbol_done", 32'(symbol_done), 0);

    // frame_start on the last allowed search sample beats the timeout.
    for (int k = 1; k <= 4095; k++) send(1'b0, 0);
    chk("pre_to_align", 32'(align_enable), 1);
    send(1'b1, 0);
    chk("edge_fs_timeout", 32'(search_timeout), 0);
    chk("edge_fs_align", 32'(align_enable), 0);
    chk("edge_fs_busy", 32'(busy), 1);
    sys_init      = 1'b1;
    frame_start   = 1'b1;
    rx_data_valid = 1'b1;
    @(negedge clk);
    sys_init      = 1'b0;
    frame_start   = 1'b0;
    rx_data_valid = 1'b0;
    chk("init_fs_align", 32'(align_enable), 1);

    // No frame_start: timeout on the 4096th search sample.
    for (int k = 1; k <= 4095; k++) send(1'b0, 0);
    chk("to_4095_timeout", 32'(search_timeout), 0);
    chk("to_4095_busy", 32'(busy), 1);
    send(1'b0, 0);
    chk("to_pulse", 32'(search_timeout), 1);
    chk("to_busy", 32'(busy), 0);
    chk("to_align", 32'(align_enable), 0);
    @(negedge clk);
    chk("to_pulse_end", 32'(search_timeout), 0);
    send(1'b1, 0);
    chk("to_idle_busy", 32'(busy), 0);

    // Asynchronous reset in the middle of DATA.
    do_init();
    send(1'b1, 0);
    for (int k = 2; k <= 20; k++) send(1'b0, 0);
    rx_data_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst_fft_valid", 32'(fft_valid), 1);
    #1;
    sys_rstn = 1'b0;
    #1;
    chk("arst_fft_valid", 32'(fft_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_align", 32'(align_enable), 0);
    chk("arst_idx", 32'(symbol_idx), 0);
    @(negedge clk);
    rx_data_valid = 1'b0;
    sys_rstn      = 1'b1;
    repeat (3) send(1'b1, 0);
    chk("post_arst_busy", 32'(busy), 0);
    chk("post_arst_fft_valid", 32'(fft_valid), 0);
    chk("post_arst_align", 32'(align_enable), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ofdm_rx_sequencer.md
OFDM_RX_SEQUENCER -- requirements
Module: ofdm_rx_sequencer

Interface
REQ-001 The block SHALL have generic symbol_length_g, default 64: useful (FFT) samples per OFDM symbol.
REQ-002 The block SHALL have generic guard_length_g, default 16: guard-interval samples per symbol, discarded.
REQ-003 The block SHALL have generic symbols_per_frame_g, default 12: symbols per frame.
REQ-004 The block SHALL have generic timeout_g, default 4096: valid samples allowed in SEARCH before abort.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset: sys_clk in 1, system clock, all logic rising-edge; sys_rstn in 1, async active-low reset.
REQ-006 The block SHALL have ports: sys_init in 1 (sync restart pulse); rx_data_valid in 1 (input sample strobe); frame_start in 1 (coarse-alignment hit, coincident with a valid sample).
REQ-007 The block SHALL have ports: align_enable out 1; fft_valid out 1; fft_start out 1; symbol_done out 1; frame_done out 1; symbol_idx out ceil(log2(symbols_per_frame_g)); search_timeout out 1; busy out 1.

Function
REQ-008 The block SHALL implement states IDLE, SEARCH, GUARD, DATA; all outputs SHALL be registered.
REQ-009 The block SHALL leave IDLE only on sys_init, entering SEARCH next cycle.
REQ-010 sys_init in any state SHALL force SEARCH next cycle, clear all counters and symbol_idx, and deassert all pulse outputs; sys_init SHALL take priority over every other event in the same cycle.
REQ-011 In SEARCH, align_enable SHALL be 1; in every other state it SHALL be 0.
REQ-012 In SEARCH, the block SHALL count valid samples; frame_start with rx_data_valid SHALL move it to GUARD, counting that sample as guard sample 1.
REQ-013 If the timeout_g-th SEARCH valid sample arrives without frame_start, the block SHALL pulse search_timeout for 1 cycle and go to IDLE; frame_start on that same sample SHALL win (GUARD, no timeout).
REQ-014 In GUARD, after guard_length_g valid samples, the block SHALL enter DATA; frame_start SHALL be ignored in GUARD and DATA.
REQ-015 In DATA, each valid sample SHALL produce fft_valid=1 exactly one cycle after its rx_data_valid; the datapath delays sample data by one register to match.
REQ-016 fft_start SHALL be 1 together with fft_valid of data sample 1 of each symbol only.
REQ-017 On the symbol_length_g-th data sample, symbol_done SHALL pulse with that sample's fft_valid.
REQ-018 On that sample, if symbol_idx < symbols_per_frame_g-1, the block SHALL increment symbol_idx and go to GUARD.
REQ-019 Otherwise the block SHALL pulse frame_done with symbol_done, clear symbol_idx, and return to SEARCH (timeout counter cleared).
REQ-020 Clocks without rx_data_valid SHALL not advance any counter; fft_valid SHALL be 0 on them.
REQ-021 busy SHALL be 1 in all states except IDLE.
REQ-022 Counters SHALL be unsigned, sized for max(timeout_g, symbol_length_g, guard_length_g), and SHALL never wrap.

Reset
REQ-023 With sys_rstn=0, the block SHALL immediately (asynchronously) enter IDLE with every output 0 and all counters 0, including mid-frame.
REQ-024 After release, the block SHALL stay in IDLE until sys_init.

Verification
REQ-025 Reset, sys_init, 10 valids (strobe every 25 clocks), then frame_start -> align_enable 1 until frame_start; first fft_start/fft_valid one cycle after 17th valid counted from frame_start.
REQ-026 Full frame with defaults -> 12 fft_start, 768 fft_valid, 12 symbol_done, symbol_idx 0..11; frame_done one cycle after 960th valid from frame_start; then SEARCH, align_enable 1.
REQ-027 Frame_start never asserted after sys_init -> search_timeout pulse one cycle after 4096th valid; busy 0, align_enable 0.
REQ-028 sys_init during DATA of symbol 5 -> next cycle SEARCH, symbol_idx 0, fft_valid 0, no symbol_done.
REQ-029 frame_start on 4096th SEARCH sample -> GUARD, no search_timeout; sys_init and frame_start same cycle -> SEARCH.
REQ-030 sys_rstn low mid-DATA -> all outputs 0 without a clock edge; after release, no activity until sys_init.
